bp_table_ctrl: RTL and testbench
================================

BP_TABLE_CTRL -- requirements
Module: bp_table_ctrl

Interface
REQ-001 Parameter ENTRIES, 256, number of single-port predictor table entries (index = pc[9:2]).
REQ-002 Parameter QDEPTH, 4, depth of the execute-stage update queue.
REQ-003 Parameter TAGW, 22, tag width (tag = pc[31:10]).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  one-cycle pulse; invalidates whole table.
REQ-007 lkp_valid  in  1  fetch-stage lookup request.
REQ-008 lkp_pc  in  32  fetch PC.
REQ-009 lkp_ready  out  1  lookup accepted when valid&&ready.
REQ-010 upd_valid  in  1  execute-stage resolved branch.
REQ-011 upd_pc, upd_target  in  32 each  branch PC, resolved target.
REQ-012 upd_taken  in  1  actual outcome.
REQ-013 upd_ctr  in  2  2-bit counter value predicted at fetch.
REQ-014 upd_ready  out  1  update accepted when valid&&ready.
REQ-015 tbl_en, tbl_we  out  1 each  table access enable, write enable.
REQ-016 tbl_idx  out  8  table index.
REQ-017 tbl_wdata  out  57  {valid, tag[21:0], target[31:0], ctr[1:0]}.
REQ-018 tbl_rdata  in  57  same layout; valid one cycle after a read.
REQ-019 pred_valid, pred_taken  out  1 each; pred_target, pred_ctr  out  32, 2.
REQ-020 busy  out  1  invalidation sweep in progress.

Function
REQ-021 FSM states SWEEP and RUN; rst or flush forces SWEEP with sweep counter 0.
REQ-022 SWEEP: one write per cycle, idx = counter, wdata all-zero; after idx 255 written, next state RUN (256 cycles total).
REQ-023 SWEEP: busy=1, lkp_ready=0, upd_ready=0, pred_valid=0.
REQ-024 flush during SWEEP restarts counter at 0; flush in RUN discards all queued updates that cycle.
REQ-025 RUN, one table access per cycle: accepted lookup reads; otherwise queue head written if queue non-empty; otherwise tbl_en=0.
REQ-026 RUN: lkp_ready = (queue count < QDEPTH); full queue stalls fetch one cycle while head drains.
REQ-027 upd_ready = RUN && count < QDEPTH, from registered count (no same-cycle pass-through when full).
REQ-028 Queue is FIFO; enqueue and dequeue in the same cycle leave count unchanged.
REQ-029 Update write: valid=1, tag=upd_pc[31:10], target=upd_target, ctr = taken ? sat_inc(upd_ctr) : sat_dec(upd_ctr) (3 saturates high, 0 low).
REQ-030 Lookup latency 1: pred_valid high the cycle after acceptance, using registered lkp_pc.
REQ-031 hit = rdata.valid && rdata.tag == registered tag; pred_taken = hit && ctr[1]; pred_target = pred_taken ? rdata.target : pc+4; pred_ctr = hit ? ctr : 2'b01.
REQ-032 No bypass: lookup of an index with a queued, unwritten update returns stale data.

Reset
REQ-033 On rst: state SWEEP, counter 0, queue empty, pred_* 0, lkp_ready 0, upd_ready 0, busy 1, tbl_en 1, tbl_we 1 next cycle.
REQ-034 rst asserted mid-sweep or mid-RUN restarts the sweep identically; queue contents lost.

Structure
REQ-035 Package bp_pkg holds ENTRIES, TAGW, index/tag bit ranges, packed entry struct, counter saturation functions.
REQ-036 Sub-module bp_upd_fifo (QDEPTH-entry synchronous FIFO with count) holds the update queue.

Verification
REQ-037 Reset, hold idle 256 cycles -> 256 zero writes idx 0..255, busy falls cycle 257, lkp_ready=1.
REQ-038 Update pc=0x0000_0040, target=0x100, taken, ctr=01, then lookup 0x40 -> write idx 16 ctr=10; pred_taken=1, target=0x100.
REQ-039 Update ctr=00 not-taken -> written ctr=00; ctr=11 taken -> written ctr=11.
REQ-040 Continuous lookups + 5 back-to-back updates -> upd_ready low after 4, lkp_ready low one cycle per drain, FIFO order preserved.
REQ-041 Lookup 0x1000_0040 with entry tag for 0x40 -> miss, pred_taken=0, target 0x1000_0044, pred_ctr=01.
REQ-042 flush with 3 queued updates in RUN -> queue empty, full 256-cycle sweep, no queued update written.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants, table entry layout and 2-bit counter helpers for the
// branch predictor table controller.
package bp_pkg;

  localparam int unsigned ENTRIES = 256;
  localparam int unsigned TAGW    = 22;
  localparam int unsigned IDXW    = 8;
  localparam int unsigned IDX_LSB = 2;
  localparam int unsigned IDX_MSB = 9;
  localparam int unsigned TAG_LSB = 10;
  localparam int unsigned TAG_MSB = 31;
  localparam int unsigned ENTRY_W = 1 + TAGW + 32 + 2;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [31:0]     target;
    logic [1:0]      ctr;
  } bp_entry_t;

  // Queued update: destination index plus the fully formed entry to write.
  typedef struct packed {
    logic [IDXW-1:0] idx;
    bp_entry_t       entry;
  } bp_upd_t;

  localparam int unsigned UPD_W = IDXW + ENTRY_W;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } bp_state_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : 2'(c + 2'b01);
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : 2'(c - 2'b01);
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO with occupancy count, holding resolved branch
// updates until a free table cycle is available.
module bp_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W = 8,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= CW'(count + CW'(do_push) - CW'(do_pop));
    end
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Arbitrates a single-port branch predictor table between fetch lookups and
// queued execute-stage updates, with a full-table invalidation sweep.
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = bp_pkg::ENTRIES,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned TAGW    = bp_pkg::TAGW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               lkp_valid,
  input  logic [31:0]        lkp_pc,
  output logic               lkp_ready,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic [31:0]        upd_target,
  input  logic               upd_taken,
  input  logic [1:0]         upd_ctr,
  output logic               upd_ready,
  output logic               tbl_en,
  output logic               tbl_we,
  output logic [IDXW-1:0]    tbl_idx,
  output logic [ENTRY_W-1:0] tbl_wdata,
  input  logic [ENTRY_W-1:0] tbl_rdata,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [31:0]        pred_target,
  output logic [1:0]         pred_ctr,
  output logic               busy
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [IDXW-1:0] SWEEP_LAST = IDXW'(ENTRIES - 1);

  bp_state_t       state_q, state_d;
  logic [IDXW-1:0] cnt_q;
  logic            pred_vld_q;
  logic [31:0]     pc_q;

  logic [CW-1:0]    fifo_cnt;
  logic [UPD_W-1:0] head_raw;
  bp_upd_t          head;
  bp_upd_t          upd_din;
  logic             q_room;
  logic             lkp_acc;
  logic             push;
  logic             pop;
  bp_entry_t        rd;
  logic             hit;
  logic             unused_upd;

  assign unused_upd = ^upd_pc[1:0];
  assign q_room     = fifo_cnt < CW'(QDEPTH);
  assign head       = bp_upd_t'(head_raw);
  assign push       = upd_valid && upd_ready;

  assign upd_din = '{
    idx:   upd_pc[IDX_MSB:IDX_LSB],
    entry: '{valid:  1'b1,
             tag:    upd_pc[TAG_MSB:TAG_LSB],
             target: upd_target,
             ctr:    upd_taken ? sat_inc(upd_ctr) : sat_dec(upd_ctr)}
  };

  bp_upd_fifo #(.DEPTH(QDEPTH), .W(UPD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .din   (upd_din),
    .pop   (pop),
    .dout  (head_raw),
    .count (fifo_cnt)
  );

  // State, sweep counter and registered lookup request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SWEEP;
      cnt_q      <= '0;
      pred_vld_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= (flush || state_q != ST_SWEEP) ? '0 : IDXW'(cnt_q + 1'b1);
      pred_vld_q <= lkp_acc;
      if (lkp_acc) pc_q <= lkp_pc;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SWEEP: if (!flush && cnt_q == SWEEP_LAST) state_d = ST_RUN;
      ST_RUN:   if (flush) state_d = ST_SWEEP;
      default:  state_d = ST_SWEEP;
    endcase
  end

  // Table port arbitration: lookups win, queued updates fill idle cycles.
  always_comb begin
    busy      = 1'b1;
    lkp_ready = 1'b0;
    upd_ready = 1'b0;
    lkp_acc   = 1'b0;
    pop       = 1'b0;
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_idx   = '0;
    tbl_wdata = '0;
    case (state_q)
      ST_SWEEP: begin
        tbl_en  = 1'b1;
        tbl_we  = 1'b1;
        tbl_idx = cnt_q;
      end
      ST_RUN: begin
        busy      = 1'b0;
        upd_ready = q_room;
        lkp_ready = q_room && !flush;
        lkp_acc   = lkp_valid && lkp_ready;
        if (lkp_acc) begin
          tbl_en  = 1'b1;
          tbl_idx = lkp_pc[IDX_MSB:IDX_LSB];
        end else if (fifo_cnt != '0 && !flush) begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_idx   = head.idx;
          tbl_wdata = head.entry;
          pop       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Prediction from the read data returned the cycle after acceptance.
  assign rd = bp_entry_t'(tbl_rdata);

  always_comb begin
    hit         = pred_vld_q && rd.valid && (rd.tag == pc_q[31:32-TAGW]);
    pred_valid  = pred_vld_q;
    pred_taken  = hit && rd.ctr[1];
    pred_target = '0;
    pred_ctr    = '0;
    if (pred_vld_q) begin
      pred_target = pred_taken ? rd.target : 32'(pc_q + 32'd4);
      pred_ctr    = hit ? rd.ctr : 2'b01;
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl: a behavioural table/queue model
// predicts writes and predictions; a negedge monitor checks them.
module tb_bp_table_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, lkp_valid, upd_valid, upd_taken;
  logic [31:0] lkp_pc, upd_pc, upd_target;
  logic [1:0]  upd_ctr;
  logic        lkp_ready, upd_ready, tbl_en, tbl_we, pred_valid, pred_taken, busy;
  logic [7:0]  tbl_idx;
  logic [56:0] tbl_wdata, tbl_rdata;
  logic [31:0] pred_target;
  logic [1:0]  pred_ctr;

  bp_table_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lkp_valid(lkp_valid), .lkp_pc(lkp_pc), .lkp_ready(lkp_ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_ctr(upd_ctr), .upd_ready(upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ctr(pred_ctr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous table memory.
  logic [56:0] mem [256];
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_idx] <= tbl_wdata;
      else        tbl_rdata    <= mem[tbl_idx];
    end
  end

  typedef struct { int due; bit tk; logic [31:0] tgt; int ctr; } pred_t;
  typedef struct { int idx; logic [21:0] tag; logic [31:0] tgt; int ctr; } wr_t;

  pred_t pq[$];
  wr_t   wq[$];

  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  logic [31:0] m_tgt   [256];
  int          m_ctr   [256];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int sw_idx = 0;
  int sw_left = 0;
  bit armed = 0;
  bit post_rst = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rpc();
    int sel;
    logic [21:0] t;
    sel = int'($urandom_range(0, 2));
    t = (sel == 2) ? 22'h40000 : 22'(sel);
    return {t, 8'(16 + $urandom_range(0, 7)), 2'b00};
  endfunction

  // Monitor: sweep writes, queued update writes and predictions.
  always @(negedge clk) begin : mon
    pred_t p;
    wr_t   w;
    if (rst) begin
      wq.delete();
      pq.delete();
      sw_idx = 0;
      sw_left = 256;
      armed = 1;
      post_rst = 1;
    end else if (armed) begin
      chk("busy", busy, sw_left > 0);
      if (sw_left > 0) begin
        chk("sweep_ctl", {tbl_en, tbl_we, tbl_idx}, {1'b1, 1'b1, 8'(sw_idx)});
        chk("sweep_data", tbl_wdata, 57'd0);
        m_valid[sw_idx] = 0;
        m_tag[sw_idx] = '0;
        m_tgt[sw_idx] = '0;
        m_ctr[sw_idx] = 0;
        sw_idx++;
        sw_left--;
      end else if (tbl_en && tbl_we) begin
        chk("wr_pending", wq.size() > 0, 1'b1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("wr_idx", tbl_idx, 8'(w.idx));
          chk("wr_data", tbl_wdata, {1'b1, w.tag, w.tgt, 2'(w.ctr)});
          m_valid[w.idx] = 1;
          m_tag[w.idx] = w.tag;
          m_tgt[w.idx] = w.tgt;
          m_ctr[w.idx] = w.ctr;
        end
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p = pq.pop_front();
        chk("pred", {pred_valid, pred_taken, pred_target, pred_ctr},
            {1'b1, p.tk, p.tgt, 2'(p.ctr)});
      end else begin
        chk("pred_idle", pred_valid, 1'b0);
        if (post_rst) chk("pred_rst", {pred_taken, pred_target, pred_ctr}, 35'd0);
      end
      post_rst = 0;
      if (flush) begin
        wq.delete();
        sw_idx = 0;
        sw_left = 256;
      end
    end
  end

  // One bench cycle: drive, check handshakes, push expectations.
  task automatic step(input bit r, input bit f, input bit lv, input logic [31:0] lpc,
                      input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input bit utk, input logic [1:0] uc, output bit uacc);
    bit er, hit;
    int i, c;
    pred_t p;
    wr_t w;
    @(posedge clk);
    #1;
    rst = r; flush = f; lkp_valid = lv; lkp_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk; upd_ctr = uc;
    #1;
    uacc = uv && upd_ready && !r;
    if (armed && !r) begin
      er = (sw_left == 0) && (wq.size() < 4);
      chk("upd_ready", upd_ready, er);
      chk("lkp_ready", lkp_ready, er && !f);
    end
    if (!r && lv && lkp_ready) begin
      i = int'(lpc[9:2]);
      hit = m_valid[i] && (m_tag[i] == lpc[31:10]);
      p.due = cyc + 1;
      p.tk = hit && (m_ctr[i] >= 2);
      p.tgt = p.tk ? m_tgt[i] : lpc + 32'd4;
      p.ctr = hit ? m_ctr[i] : 1;
      pq.push_back(p);
      chk("rd_access", {tbl_en, tbl_we, tbl_idx}, {1'b1, 1'b0, lpc[9:2]});
    end
    if (uacc) begin
      c = int'(uc);
      w.idx = int'(upc[9:2]);
      w.tag = upc[31:10];
      w.tgt = utgt;
      w.ctr = utk ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
      wq.push_back(w);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 2'b00, a);
  endtask

  task automatic lookup(input logic [31:0] pc);
    bit a;
    step(0, 0, 1, pc, 0, 32'h0, 32'h0, 0, 2'b00, a);
  endtask

  // Hold one update until accepted, optionally with back-to-back lookups.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                     input logic [1:0] c, input bit lv);
    bit a;
    a = 0;
    for (int k = 0; k < 20 && !a; k++) step(0, 0, lv, rpc(), 1, pc, tgt, tk, c, a);
    chk("upd_accept", a, 1'b1);
  endtask

  initial begin : stim
    bit a, r, f;
    rst = 1; flush = 0; lkp_valid = 0; lkp_pc = 0; upd_valid = 0;
    upd_pc = 0; upd_target = 0; upd_taken = 0; upd_ctr = 0;
    step(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 2'b00, a);
    step(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 2'b00, a);
    idle(260);

    upd(32'h0000_0040, 32'h0000_0100, 1, 2'b01, 0);
    idle(2);
    lookup(32'h0000_0040);
    upd(32'h0000_0080, 32'h0000_0200, 0, 2'b00, 0);
    upd(32'h0000_00C0, 32'h0000_0300, 1, 2'b11, 0);
    idle(3);
    lookup(32'h0000_0080);
    lookup(32'h0000_00C0);
    lookup(32'h1000_0040);

    // Update immediately followed by a lookup of the same index sees old data.
    upd(32'h0000_0040, 32'h0000_0400, 0, 2'b10, 0);
    lookup(32'h0000_0040);
    idle(2);
    lookup(32'h0000_0040);

    for (int k = 0; k < 5; k++) upd(32'h0000_0040 + 32'(k * 4), 32'h1000 + 32'(k), 1, 2'b01, 1);
    for (int k = 0; k < 4; k++) lookup(rpc());
    idle(8);

    // Flush with three queued updates.
    for (int k = 0; k < 3; k++) upd(32'h0000_0050 + 32'(k * 4), 32'h2000, 1, 2'b10, 1);
    step(0, 1, 1, rpc(), 0, 32'h0, 32'h0, 0, 2'b00, a);
    idle(258);
    lookup(32'h0000_0050);
    lookup(32'h0000_0040);

    for (int n = 0; n < 2500; n++) begin
      r = ($urandom_range(0, 1499) == 0);
      f = !r && ($urandom_range(0, 399) == 0);
      step(r, f, 1'($urandom_range(0, 1)), rpc(), 1'($urandom_range(0, 1)), rpc(),
           $urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a);
    end
    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
